amp_power_sequencer: RTL and testbench
======================================

Name: amp_power_sequencer

Overview:
- Client-side controller for the one-shot countdown timer: it issues the timer start pulse and consumes the timer's done/idle level.
- Sequences the class-D power stage on and off: bias, then driver, then unmute; the reverse order on shutdown.
- Each step's dwell time comes from one shared timer instance. One timed interval is in flight at a time.
- Sits between the top-level enable/fault logic and the power-stage enables.

Parameters:
- ARM_LIMIT, 4: max cycles after a tmr_start pulse for tmr_done to fall before a timer fault is declared (range 2..15).
- ARM_W, 4: width of the arm-watch counter; must hold ARM_LIMIT.

Ports:
- clk_in  input  1  system clock; everything is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  level request: 1 = power up and stay on, 0 = power down.
- fault_in  input  1  level fault from the protection block (OCP/OTP).
- tmr_done  input  1  timer status: 1 = idle/expired, 0 = counting.
- tmr_start  output  1  registered one-cycle pulse that starts the timer.
- bias_en  output  1  bias/regulator enable.
- drv_en  output  1  gate-driver enable.
- mute_n  output  1  0 = output muted.
- ready  output  1  1 only in state ON.
- seq_fault  output  1  1 while in state FAULT.
- fault_code  output  2  00 none, 01 external fault, 10 timer did not arm; holds until FAULT is exited.
- state_o  output  3  current state encoding, for debug.

Behaviour:
- Reset (reset=1 at an edge): state OFF. All outputs 0. Arm counter 0, abort flag 0. Reset overrides everything, mid-sequence included.
- States and encodings: OFF=0, PU_BIAS=1, PU_DRV=2, ON=3, PD_MUTE=4, PD_DRV=5, FAULT=6. Encoding 7 is illegal and recovers to FAULT with code 10.
- Timed states are PU_BIAS, PU_DRV, PD_MUTE and PD_DRV. Each has two sub-phases:
  - On the entry edge, tmr_start=1 for exactly one cycle; the sub-phase is ARM and the arm counter clears.
  - ARM: wait for tmr_done=0. The arm counter increments each cycle tmr_done=1. Reaching ARM_LIMIT goes to FAULT with code 10.
  - WAIT: entered on the first sampled tmr_done=0. On the first sampled tmr_done=1 the interval has expired; transition on that edge.
- Transitions and output updates happen on the same edge:
  - OFF → PU_BIAS when enable=1 and tmr_done=1; bias_en←1.
  - PU_BIAS expires → PU_DRV; drv_en←1.
  - PU_DRV expires → ON; mute_n←1, ready←1.
  - ON with enable=0 → PD_MUTE; mute_n←0, ready←0.
  - PD_MUTE expires → PD_DRV; drv_en←0.
  - PD_DRV expires → OFF; bias_en←0.
- Abort during power-up:
  - enable=0 while in PU_BIAS or PU_DRV sets the abort flag. The running interval is never cut short, because the timer ignores a start while counting.
  - At expiry with abort=1, go to PD_MUTE instead of the next up-state. abort clears and drv_en/bias_en keep their current values.
  - enable returning to 1 before expiry does not clear abort.
- Power-down is never aborted: enable=1 during PD_* is ignored until OFF is reached.
- Fault:
  - fault_in=1 in any non-FAULT state → FAULT on the next edge, with code 01. This has priority over every other transition, including a same-cycle expiry.
  - In FAULT, bias_en, drv_en, mute_n, ready and tmr_start are 0 and seq_fault=1.
  - Exit FAULT → OFF when fault_in=0, enable=0 and tmr_done=1 are all true in the same cycle. fault_code clears on exit.
- tmr_start is asserted only on entry to a timed state. It is never asserted in OFF, ON or FAULT, and never twice for one interval.
- Minimum power-up to ready = 2 × (timer interval + start latency) cycles. The block adds no extra cycles beyond a 1-cycle registered response.

Test Plan:
- Timer model with a 16-cycle interval; reset, then enable=1 → one tmr_start pulse in each of PU_BIAS and PU_DRV. bias_en, drv_en and mute_n rise in order. ready=1 about 2 intervals after enable; state_o goes 0,1,2,3.
- From ON, enable=0 → mute_n=0 on the next edge; drv_en falls 1 interval later and bias_en 1 interval after that; state_o ends at 0. Exactly 2 tmr_start pulses.
- enable=1, then enable=0 mid PU_BIAS (cycle 5) → bias_en stays 1 until expiry, then PD_MUTE, PD_DRV, OFF. drv_en never rises; 3 tmr_start pulses in total.
- Timer model holds tmr_done=1 permanently → FAULT ARM_LIMIT cycles after the first tmr_start. seq_fault=1, fault_code=10, all enables 0.
- fault_in pulsed high in ON for 1 cycle → FAULT on the next edge, code 01. The block stays in FAULT while enable=1; after enable=0 it returns to OFF.
- reset asserted mid PU_DRV → all outputs 0 at the next edge and state_o=0. enable held at 1 afterwards restarts cleanly once tmr_done=1.

Source files
------------

// File: rtl/amp_power_sequencer_if.sv
// rtl/amp_power_sequencer_if.sv - control, timer handshake and power-stage signals of the amp sequencer
interface amp_power_sequencer_if;
  logic       enable;
  logic       fault_in;
  logic       tmr_done;
  logic       tmr_start;
  logic       bias_en;
  logic       drv_en;
  logic       mute_n;
  logic       ready;
  logic       seq_fault;
  logic [1:0] fault_code;
  logic [2:0] state_o;

  modport master (
    input  enable, fault_in, tmr_done,
    output tmr_start, bias_en, drv_en, mute_n, ready, seq_fault, fault_code, state_o
  );

  modport slave (
    output enable, fault_in, tmr_done,
    input  tmr_start, bias_en, drv_en, mute_n, ready, seq_fault, fault_code, state_o
  );
endinterface

// File: rtl/amp_power_sequencer.sv
// rtl/amp_power_sequencer.sv - class-D power stage on/off sequencer driving a shared one-shot timer
module amp_power_sequencer #(
  parameter int ARM_LIMIT = 4,
  parameter int ARM_W     = 4
) (
  input  logic                        clk_in,
  input  logic                        reset,
  amp_power_sequencer_if.master       bus
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_PU_BIAS = 3'd1,
    S_PU_DRV  = 3'd2,
    S_ON      = 3'd3,
    S_PD_MUTE = 3'd4,
    S_PD_DRV  = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  state_t           r_state;
  logic             r_wait;
  logic [ARM_W-1:0] r_arm_cnt;
  logic             r_abort;
  logic             r_tmr_start;
  logic             r_bias_en;
  logic             r_drv_en;
  logic             r_mute_n;
  logic             r_ready;
  logic             r_seq_fault;
  logic [1:0]       r_fault_code;

  logic w_timed;
  logic w_pu;
  logic w_expire;
  logic w_arm_to;
  logic w_illegal;
  logic w_ext_fault;
  logic w_to_fault;
  logic w_abort;

  assign w_pu        = (r_state == S_PU_BIAS) || (r_state == S_PU_DRV);
  assign w_timed     = w_pu || (r_state == S_PD_MUTE) || (r_state == S_PD_DRV);
  assign w_expire    = w_timed && r_wait && bus.tmr_done;
  assign w_arm_to    = w_timed && !r_wait && bus.tmr_done &&
                       (r_arm_cnt == ARM_W'(ARM_LIMIT - 1));
  assign w_illegal   = (r_state == state_t'(3'b111));
  assign w_ext_fault = bus.fault_in && (r_state != S_FAULT);
  assign w_to_fault  = w_ext_fault || w_arm_to || w_illegal;
  // An enable drop on the very expiry cycle still aborts the power-up.
  assign w_abort     = r_abort || !bus.enable;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state      <= S_OFF;
      r_wait       <= 1'b0;
      r_arm_cnt    <= '0;
      r_abort      <= 1'b0;
      r_tmr_start  <= 1'b0;
      r_bias_en    <= 1'b0;
      r_drv_en     <= 1'b0;
      r_mute_n     <= 1'b0;
      r_ready      <= 1'b0;
      r_seq_fault  <= 1'b0;
      r_fault_code <= 2'b00;
    end else begin
      r_tmr_start <= 1'b0;
      if (w_to_fault) begin
        r_state      <= S_FAULT;
        r_wait       <= 1'b0;
        r_arm_cnt    <= '0;
        r_abort      <= 1'b0;
        r_bias_en    <= 1'b0;
        r_drv_en     <= 1'b0;
        r_mute_n     <= 1'b0;
        r_ready      <= 1'b0;
        r_seq_fault  <= 1'b1;
        r_fault_code <= w_ext_fault ? 2'b01 : 2'b10;
      end else begin
        case (r_state)
          S_OFF: begin
            if (bus.enable && bus.tmr_done) begin
              r_state     <= S_PU_BIAS;
              r_bias_en   <= 1'b1;
              r_tmr_start <= 1'b1;
              r_wait      <= 1'b0;
              r_arm_cnt   <= '0;
              r_abort     <= 1'b0;
            end
          end
          S_PU_BIAS, S_PU_DRV, S_PD_MUTE, S_PD_DRV: begin
            if (w_pu && !bus.enable) r_abort <= 1'b1;
            if (!r_wait) begin
              if (!bus.tmr_done) r_wait <= 1'b1;
              else               r_arm_cnt <= r_arm_cnt + 1'b1;
            end else if (w_expire) begin
              r_wait    <= 1'b0;
              r_arm_cnt <= '0;
              r_abort   <= 1'b0;
              if (w_pu && w_abort) begin
                r_state     <= S_PD_MUTE;
                r_tmr_start <= 1'b1;
              end else begin
                case (r_state)
                  S_PU_BIAS: begin
                    r_state     <= S_PU_DRV;
                    r_drv_en    <= 1'b1;
                    r_tmr_start <= 1'b1;
                  end
                  S_PU_DRV: begin
                    r_state  <= S_ON;
                    r_mute_n <= 1'b1;
                    r_ready  <= 1'b1;
                  end
                  S_PD_MUTE: begin
                    r_state     <= S_PD_DRV;
                    r_drv_en    <= 1'b0;
                    r_tmr_start <= 1'b1;
                  end
                  default: begin
                    r_state   <= S_OFF;
                    r_bias_en <= 1'b0;
                  end
                endcase
              end
            end
          end
          S_ON: begin
            if (!bus.enable) begin
              r_state     <= S_PD_MUTE;
              r_mute_n    <= 1'b0;
              r_ready     <= 1'b0;
              r_tmr_start <= 1'b1;
              r_wait      <= 1'b0;
              r_arm_cnt   <= '0;
            end
          end
          S_FAULT: begin
            if (!bus.fault_in && !bus.enable && bus.tmr_done) begin
              r_state      <= S_OFF;
              r_seq_fault  <= 1'b0;
              r_fault_code <= 2'b00;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.tmr_start  = r_tmr_start;
  assign bus.bias_en    = r_bias_en;
  assign bus.drv_en     = r_drv_en;
  assign bus.mute_n     = r_mute_n;
  assign bus.ready      = r_ready;
  assign bus.seq_fault  = r_seq_fault;
  assign bus.fault_code = r_fault_code;
  assign bus.state_o    = r_state;

endmodule

// File: tb/tb_amp_power_sequencer.sv
// tb/tb_amp_power_sequencer.sv - scoreboard bench for amp_power_sequencer with a 16-cycle timer model
module tb_amp_power_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  amp_power_sequencer_if u_if ();

  amp_power_sequencer #(.ARM_LIMIT(4), .ARM_W(4)) dut (
    .clk_in (clk),
    .reset  (reset),
    .bus    (u_if.master)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int starts = 0;
  int t_enter[8];
  logic mon_on = 1'b0;
  logic [9:0] prev_snap = '0;
  logic [9:0] exp_q[$];
  logic [9:0] snap;

  // One-shot timer: ignores start while counting; stuck forces done high.
  logic stuck = 1'b0;
  logic [4:0] tcnt = '0;
  assign u_if.tmr_done = stuck | (tcnt == 5'd0);
  always @(posedge clk) begin
    if (!stuck) begin
      if (tcnt == 5'd0) begin
        if (u_if.tmr_start) tcnt <= 5'd16;
      end else begin
        tcnt <= tcnt - 5'd1;
      end
    end
  end
  always @(posedge clk) cyc <= cyc + 1;

  assign snap = {u_if.state_o, u_if.bias_en, u_if.drv_en, u_if.mute_n,
                 u_if.ready, u_if.seq_fault, u_if.fault_code};

  function automatic logic [9:0] ex(input logic [2:0] st, input logic b, input logic d,
                                    input logic m, input logic r, input logic sf,
                                    input logic [1:0] code);
    return {st, b, d, m, r, sf, code};
  endfunction

  // Monitor: every change of the observed output set consumes one expectation.
  always @(negedge clk) begin
    logic [9:0] e;
    if (u_if.tmr_start === 1'b1) starts++;
    if (mon_on && snap !== prev_snap) begin
      t_enter[u_if.state_o] = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change got=%h required=none", snap);
      end else begin
        e = exp_q.pop_front();
        if (snap !== e) begin
          failures++;
          $display("FAIL transition got=%h required=%h", snap, e);
        end
      end
      prev_snap = snap;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_state(input string name, input int s, input int budget);
    int n = 0;
    while (int'(u_if.state_o) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk(name, int'(u_if.state_o), s);
  endtask

  task automatic push_power_up();
    exp_q.push_back(ex(3'd1, 1, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(ex(3'd2, 1, 1, 0, 0, 0, 2'b00));
    exp_q.push_back(ex(3'd3, 1, 1, 1, 1, 0, 2'b00));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.enable = 1'b0;
    u_if.fault_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(snap), 0);
    chk("reset_tmr_start", int'(u_if.tmr_start), 0);
    reset = 1'b0;
    prev_snap = snap;
    mon_on = 1'b1;

    // Power-up: two intervals of 18 cycles (start latency + 16 + done sampling).
    push_power_up();
    starts = 0;
    u_if.enable = 1'b1;
    wait_state("pu_reach_on", 3, 200);
    repeat (4) @(negedge clk);
    chk("pu_starts", starts, 2);
    chk("pu_latency", t_enter[3] - t_enter[1], 36);

    // Power-down from ON.
    exp_q.push_back(ex(3'd4, 1, 1, 0, 0, 0, 2'b00));
    exp_q.push_back(ex(3'd5, 1, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(ex(3'd0, 0, 0, 0, 0, 0, 2'b00));
    starts = 0;
    #1 u_if.enable = 1'b0;
    wait_state("pd_reach_off", 0, 200);
    chk("pd_starts", starts, 2);
    chk("pd_drv_interval", t_enter[5] - t_enter[4], 18);
    chk("pd_bias_interval", t_enter[0] - t_enter[5], 18);

    // Abort mid PU_BIAS: bias held until expiry, driver never enabled.
    exp_q.push_back(ex(3'd1, 1, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(ex(3'd4, 1, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(ex(3'd5, 1, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(ex(3'd0, 0, 0, 0, 0, 0, 2'b00));
    starts = 0;
    u_if.enable = 1'b1;
    wait_state("abort_reach_bias", 1, 10);
    repeat (5) @(negedge clk);
    #1 u_if.enable = 1'b0;
    wait_state("abort_reach_off", 0, 300);
    chk("abort_starts", starts, 3);
    chk("abort_full_interval", t_enter[4] - t_enter[1], 18);

    // Timer never arms.
    stuck = 1'b1;
    exp_q.push_back(ex(3'd1, 1, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(ex(3'd6, 0, 0, 0, 0, 1, 2'b10));
    u_if.enable = 1'b1;
    wait_state("arm_reach_fault", 6, 50);
    chk("arm_fault_latency", t_enter[6] - t_enter[1], 4);
    chk("arm_fault_code", int'(u_if.fault_code), 2);
    exp_q.push_back(ex(3'd0, 0, 0, 0, 0, 0, 2'b00));
    u_if.enable = 1'b0;
    wait_state("arm_exit_off", 0, 10);
    stuck = 1'b0;

    // External fault pulse while ON; FAULT holds while enable stays high.
    push_power_up();
    u_if.enable = 1'b1;
    wait_state("ext_reach_on", 3, 200);
    exp_q.push_back(ex(3'd6, 0, 0, 0, 0, 1, 2'b01));
    u_if.fault_in = 1'b1;
    @(negedge clk);
    #1 u_if.fault_in = 1'b0;
    chk("ext_fault_next_edge", int'(u_if.state_o), 6);
    repeat (10) @(negedge clk);
    chk("ext_fault_hold", int'(u_if.state_o), 6);
    chk("ext_fault_code", int'(u_if.fault_code), 1);
    chk("ext_no_start", int'(u_if.tmr_start), 0);
    exp_q.push_back(ex(3'd0, 0, 0, 0, 0, 0, 2'b00));
    #1 u_if.enable = 1'b0;
    wait_state("ext_exit_off", 0, 10);

    // Reset mid PU_DRV, then clean restart with enable held.
    exp_q.push_back(ex(3'd1, 1, 0, 0, 0, 0, 2'b00));
    exp_q.push_back(ex(3'd2, 1, 1, 0, 0, 0, 2'b00));
    starts = 0;
    u_if.enable = 1'b1;
    wait_state("rst_reach_drv", 2, 100);
    repeat (3) @(negedge clk);
    exp_q.push_back(ex(3'd0, 0, 0, 0, 0, 0, 2'b00));
    #1 reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_state", int'(u_if.state_o), 0);
    chk("rst_tmr_start", int'(u_if.tmr_start), 0);
    reset = 1'b0;
    push_power_up();
    wait_state("rst_restart_on", 3, 300);
    chk("rst_starts", starts, 4);

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
